iserdes_word_aligner: RTL and testbench

- Fabric-side word-alignment controller for NUM_CH I_SERDES channels of WIDTH bits each.
- Sits between the I_SERDES Q/DATA_VALID outputs and user logic, in the I_SERDES CLK_OUT (fabric clock) domain.
- Hunts for a training pattern on each channel and pulses that channel's BITSLIP_ADJ until the pattern is seen MATCH_COUNT times in a row.
- Then declares the channel aligned and forwards registered data.

---
 rtl/iserdes_align_pkg.sv | 37 +++
 rtl/iserdes_align_ch.sv | 148 ++++++++++++++
 rtl/iserdes_word_aligner.sv | 72 +++++++
 tb/tb_iserdes_word_aligner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iserdes_align_pkg.sv
// Shared types and helpers for the I_SERDES word aligner.
// Holds the channel state encoding and parameter legality checks.
package iserdes_align_pkg;

  localparam int W_MIN  = 3;
  localparam int W_MAX  = 10;
  localparam int CH_MIN = 1;
  localparam int CH_MAX = 16;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HUNT      = 3'd1,
    ST_SLIP      = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  // Bits needed to index v values; never below 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_ok(
    input int w,
    input int n,
    input int mc
  );
    return (w >= W_MIN) && (w <= W_MAX) &&
           (n >= CH_MIN) && (n <= CH_MAX) &&
           (mc >= 1);
  endfunction

endpackage

// File: rtl/iserdes_align_ch.sv
// One channel of the word aligner: hunt/slip/settle FSM,
// match and slip counters, and the aligned output register.
module iserdes_align_ch
  import iserdes_align_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(4'b0011),
  parameter int MATCH_COUNT = 4,
  parameter int SLIP_WAIT = 2,
  parameter int MAX_SLIPS = 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pll_lock_i,
  input  logic             train_en_i,
  input  logic             train_rise_i,
  input  logic             dv_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             bitslip_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             aligned_o,
  output logic             fail_o
);

  localparam int MW = clog2(MATCH_COUNT + 1);
  localparam int SW = clog2(MAX_SLIPS + 1);
  localparam int TW = clog2(SLIP_WAIT + 1);

  localparam logic [MW-1:0] MATCH_MAX  = MW'(MATCH_COUNT);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);
  localparam logic [TW-1:0] SETTLE_MAX = TW'(SLIP_WAIT);

  state_e           state_q, state_d;
  logic [MW-1:0]    match_q, match_d;
  logic [SW-1:0]    slip_q, slip_d;
  logic [TW-1:0]    settle_q, settle_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    slip_d    = slip_q;
    settle_d  = settle_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (!pll_lock_i) begin
      state_d  = ST_WAIT_LOCK;
      match_d  = '0;
      slip_d   = '0;
      settle_d = '0;
    end else if (train_rise_i) begin
      state_d  = ST_HUNT;
      match_d  = '0;
      slip_d   = '0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          match_d  = '0;
          slip_d   = '0;
          settle_d = '0;
          if (train_en_i) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (!train_en_i) begin
            state_d = ST_WAIT_LOCK;
            match_d = '0;
            slip_d  = '0;
          end else if (dv_i) begin
            if (q_i == TRAIN_PATTERN) begin
              if (match_q != MATCH_MAX)
                match_d = match_q + MW'(1);
              if (match_d == MATCH_MAX)
                state_d = ST_LOCKED;
            end else begin
              match_d = '0;
              state_d = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          // The pulse is already on the pins this cycle.
          if (slip_q != SLIP_MAX)
            slip_d = slip_q + SW'(1);
          settle_d = '0;
          if (!train_en_i) begin
            state_d = ST_WAIT_LOCK;
            match_d = '0;
            slip_d  = '0;
          end else if (slip_d == SLIP_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!train_en_i) begin
            state_d  = ST_WAIT_LOCK;
            match_d  = '0;
            slip_d   = '0;
            settle_d = '0;
          end else if (SLIP_WAIT == 0) begin
            state_d = ST_HUNT;
          end else if (dv_i) begin
            settle_d = settle_q + TW'(1);
            if (settle_d == SETTLE_MAX)
              state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (dv_i) begin
            q_valid_d = 1'b1;
            q_d       = q_i;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_WAIT_LOCK;
      match_q   <= '0;
      slip_q    <= '0;
      settle_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      settle_q  <= settle_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bitslip_o = (state_q == ST_SLIP);
  assign aligned_o = (state_q == ST_LOCKED);
  assign fail_o    = (state_q == ST_FAIL);
  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;

endmodule

// File: rtl/iserdes_word_aligner.sv
// Multi-channel I_SERDES word aligner in the CLK_OUT domain.
// Shares one TRAIN_EN edge detector and the ALL_ALIGNED flag.
module iserdes_word_aligner
  import iserdes_align_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NUM_CH = 1,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(4'b0011),
  parameter int MATCH_COUNT = 4,
  parameter int SLIP_WAIT = 2,
  parameter int MAX_SLIPS = 2 * WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    PLL_LOCK,
  input  logic                    TRAIN_EN,
  input  logic [NUM_CH-1:0]       DATA_VALID,
  input  logic [NUM_CH*WIDTH-1:0] Q_IN,
  output logic [NUM_CH-1:0]       BITSLIP_ADJ,
  output logic [NUM_CH*WIDTH-1:0] Q_OUT,
  output logic [NUM_CH-1:0]       Q_VALID,
  output logic [NUM_CH-1:0]       ALIGNED,
  output logic [NUM_CH-1:0]       ALIGN_FAIL,
  output logic                    ALL_ALIGNED
);

  if (!params_ok(WIDTH, NUM_CH, MATCH_COUNT)) begin : g_bad_params
    $error("iserdes_word_aligner: illegal parameters");
  end

  logic train_q;
  logic all_q;
  logic train_rise;

  assign train_rise = TRAIN_EN & ~train_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    iserdes_align_ch #(
      .WIDTH         (WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SLIP_WAIT     (SLIP_WAIT),
      .MAX_SLIPS     (MAX_SLIPS)
    ) u_ch (
      .clk_i        (CLK),
      .rst_i        (RST),
      .pll_lock_i   (PLL_LOCK),
      .train_en_i   (TRAIN_EN),
      .train_rise_i (train_rise),
      .dv_i         (DATA_VALID[c]),
      .q_i          (Q_IN[c*WIDTH +: WIDTH]),
      .bitslip_o    (BITSLIP_ADJ[c]),
      .q_o          (Q_OUT[c*WIDTH +: WIDTH]),
      .q_valid_o    (Q_VALID[c]),
      .aligned_o    (ALIGNED[c]),
      .fail_o       (ALIGN_FAIL[c])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      train_q <= 1'b0;
      all_q   <= 1'b0;
    end else begin
      train_q <= TRAIN_EN;
      all_q   <= &ALIGNED;
    end
  end

  assign ALL_ALIGNED = all_q;

endmodule

// File: tb/tb_iserdes_word_aligner.sv
// Directed bench for iserdes_word_aligner with a Q_OUT scoreboard
// and a bitslip-driven rotation model of the serial link.
module tb_iserdes_word_aligner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pll, ten;
  logic [0:0] dv1, bs1, qv1, al1, af1;
  logic [3:0] q1, qo1;
  logic       all1;

  logic       rst2, pll2, ten2;
  logic [1:0] dv2, bs2, qv2, al2, af2;
  logic [7:0] q2, qo2;
  logic       all2;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] sb[$];
  logic [3:0] w1, w2a, w2b, v, last_fwd;
  int cyc = 0;
  int last_slip1 = -100;
  int nslip1 = 0;
  int nbs2a = 0;
  int nbs2b = 0;
  int k, k0, k1, ka;
  bit gap_bad = 1'b0;

  iserdes_word_aligner u1 (
    .CLK         (clk),
    .RST         (rst),
    .PLL_LOCK    (pll),
    .TRAIN_EN    (ten),
    .DATA_VALID  (dv1),
    .Q_IN        (q1),
    .BITSLIP_ADJ (bs1),
    .Q_OUT       (qo1),
    .Q_VALID     (qv1),
    .ALIGNED     (al1),
    .ALIGN_FAIL  (af1),
    .ALL_ALIGNED (all1)
  );

  iserdes_word_aligner #(.NUM_CH(2)) u2 (
    .CLK         (clk),
    .RST         (rst2),
    .PLL_LOCK    (pll2),
    .TRAIN_EN    (ten2),
    .DATA_VALID  (dv2),
    .Q_IN        (q2),
    .BITSLIP_ADJ (bs2),
    .Q_OUT       (qo2),
    .Q_VALID     (qv2),
    .ALIGNED     (al2),
    .ALIGN_FAIL  (af2),
    .ALL_ALIGNED (all2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, apply link rotation, drive.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bs1 === 1'b1) begin
      nslip1++;
      if (cyc - last_slip1 < 4) gap_bad = 1'b1;
      last_slip1 = cyc;
      w1 = {w1[0], w1[3:1]};
    end
    if (bs2[0] === 1'b1) begin
      nbs2a++;
      w2a = {w2a[0], w2a[3:1]};
    end
    if (bs2[1] === 1'b1) begin
      nbs2b++;
      w2b = {w2b[0], w2b[3:1]};
    end
    q1 = w1;
    q2 = {w2b, w2a};
  endtask

  task automatic drive1(input logic [3:0] d);
    w1 = d;
    q1 = d;
  endtask

  always @(negedge clk) begin
    if (qv1 === 1'b1) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_extra: observed q_valid with %0d queued, expected >0",
               sb.size());
      end
      if (sb.size() > 0)
        chk("sb_data", 32'(qo1), 32'(sb.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; pll = 1'b1; ten = 1'b0;
    dv1 = '0; q1 = '0; w1 = '0;
    rst2 = 1'b1; pll2 = 1'b1; ten2 = 1'b0;
    dv2 = '0; q2 = '0; w2a = '0; w2b = '0;
    last_fwd = '0;
    repeat (3) step();
    chk("rst_aligned", 32'(al1), 0);
    chk("rst_fail", 32'(af1), 0);
    chk("rst_qvalid", 32'(qv1), 0);
    chk("rst_bitslip", 32'(bs1), 0);
    chk("rst_all", 32'(all1), 0);
    chk("rst_qout", 32'(qo1), 0);
    chk("rst2_aligned", 32'(al2), 0);
    chk("rst2_bitslip", 32'(bs2), 0);

    rst = 1'b0;
    repeat (3) step();
    chk("idle_aligned", 32'(al1), 0);
    chk("idle_slips", nslip1, 0);

    // Pre-aligned link
    ten = 1'b1; dv1 = 1'b1;
    drive1(4'b0011);
    repeat (4) step();
    chk("t1_not_yet", 32'(al1), 0);
    step();
    chk("t1_aligned", 32'(al1), 1);
    chk("t1_qv_first", 32'(qv1), 0);
    chk("t1_all_lag", 32'(all1), 0);
    chk("t1_no_slip", nslip1, 0);
    for (int i = 0; i < 8; i++) begin
      v = 4'(i * 5 + 1);
      dv1 = (i != 3);
      drive1(v);
      if (i != 3) begin
        sb.push_back(v);
        last_fwd = v;
      end
      step();
      chk("t1_qvalid", 32'(qv1), 32'(i != 3));
      if (i == 3) chk("t1_hold", 32'(qo1), 32'(last_fwd));
      if (i == 0) chk("t1_all", 32'(all1), 1);
    end

    // PLL drop while locked
    pll = 1'b0;
    drive1(4'hE);
    step();
    chk("pll_aligned", 32'(al1), 0);
    chk("pll_qvalid", 32'(qv1), 0);
    chk("pll_qout", 32'(qo1), 32'(last_fwd));
    step();
    chk("pll_all", 32'(all1), 0);
    pll = 1'b1;
    drive1(4'b0011);
    repeat (4) step();
    chk("relock_early", 32'(al1), 0);
    step();
    chk("relock", 32'(al1), 1);
    dv1 = 1'b0;
    ten = 1'b0;
    repeat (3) step();
    chk("ten_low_locked", 32'(al1), 1);

    // Link one bit off
    nslip1 = 0;
    ten = 1'b1; dv1 = 1'b1;
    drive1(4'b0110);
    k = 0;
    do begin
      step();
      k++;
    end while (al1 !== 1'b1 && k < 40);
    dv1 = 1'b0;
    chk("t2_lock_cycle", k, 9);
    chk("t2_slips", nslip1, 1);
    chk("t2_fail", 32'(af1), 0);

    // Pattern never appears
    ten = 1'b0;
    step();
    ten = 1'b1; dv1 = 1'b1;
    drive1(4'b0000);
    nslip1 = 0; gap_bad = 1'b0; last_slip1 = -100;
    k = 0;
    do begin
      step();
      k++;
    end while (af1 !== 1'b1 && k < 100);
    chk("t3_fail_cycle", k, 31);
    chk("t3_fail_flag", 32'(af1), 1);
    chk("t3_slips", nslip1, 8);
    chk("t3_gap", 32'(gap_bad), 0);
    chk("t3_aligned", 32'(al1), 0);
    repeat (10) step();
    chk("t3_no_more_slips", nslip1, 8);
    chk("t3_sticky", 32'(af1), 1);
    ten = 1'b0;
    step();
    chk("t3_ten_low", 32'(af1), 1);
    ten = 1'b1;
    drive1(4'b0011);
    step();
    chk("t3_fail_cleared", 32'(af1), 0);
    repeat (4) step();
    chk("t3_relock", 32'(al1), 1);
    dv1 = 1'b0;

    // Reset landing on the slip cycle
    ten = 1'b0;
    step();
    ten = 1'b1; dv1 = 1'b1;
    drive1(4'b0110);
    nslip1 = 0;
    step();
    step();
    chk("t6_bs_seen", 32'(bs1), 1);
    rst = 1'b1; ten = 1'b0;
    step();
    chk("t6_bitslip", 32'(bs1), 0);
    chk("t6_aligned", 32'(al1), 0);
    chk("t6_fail", 32'(af1), 0);
    chk("t6_qvalid", 32'(qv1), 0);
    chk("t6_all", 32'(all1), 0);
    chk("t6_qout", 32'(qo1), 0);
    rst = 1'b0;
    repeat (5) step();
    chk("t6_parked", 32'(al1), 0);
    chk("t6_no_slip", nslip1, 1);
    ten = 1'b1;
    drive1(4'b0011);
    repeat (5) step();
    chk("t6_relock", 32'(al1), 1);
    dv1 = 1'b0;

    // Two channels, 0 and 3 slips
    rst2 = 1'b0; ten2 = 1'b1; dv2 = 2'b11;
    w2a = 4'b0011; w2b = 4'b1001;
    q2 = {w2b, w2a};
    k = 0; k0 = -1; k1 = -1; ka = -1;
    do begin
      step();
      k++;
      if (al2[0] === 1'b1 && k0 < 0) k0 = k;
      if (al2[1] === 1'b1 && k1 < 0) k1 = k;
      if (all2 === 1'b1 && ka < 0) ka = k;
    end while (ka < 0 && k < 80);
    chk("t5_ch0_lock", k0, 5);
    chk("t5_ch1_lock", k1, 17);
    chk("t5_all_lock", ka, 18);
    chk("t5_bs0", nbs2a, 0);
    chk("t5_bs1", nbs2b, 3);
    chk("t5_fail", 32'(af2), 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
